// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg
//   Shared types and default parameter values for the motor_ctrl block.
//   motor_state_e : per-channel FSM state (IDLE, FWD, REV, DEAD, FAULT)
//   *_DEF         : default values for N_CH, DEAD_CYC and TIMEOUT_CYC
package motor_ctrl_pkg;

   localparam int N_CH_DEF        = 2;
   localparam int DEAD_CYC_DEF    = 4;
   localparam int TIMEOUT_CYC_DEF = 1000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FWD   = 3'd1,
      ST_REV   = 3'd2,
      ST_DEAD  = 3'd3,
      ST_FAULT = 3'd4
   } motor_state_e;

endpackage

// File: rtl/motor_ctrl_if.sv
// motor_ctrl_if
//   Groups the per-channel command, limit and status vectors of motor_ctrl.
//   cmd_fwd/cmd_rev : run requests, level-sensitive
//   lim_fwd/lim_rev : end-of-travel switches, 1 = reached
//   fault_clr       : fault acknowledge, single-cycle pulse
//   drv_fwd/drv_rev : registered motor drives
//   busy/fault      : channel status
//   modport master : controller side issuing commands (system / bench)
//   modport slave  : motor_ctrl side
interface motor_ctrl_if
   import motor_ctrl_pkg::*;
#(
   parameter int N_CH = N_CH_DEF
);

   logic [N_CH-1:0] cmd_fwd;
   logic [N_CH-1:0] cmd_rev;
   logic [N_CH-1:0] lim_fwd;
   logic [N_CH-1:0] lim_rev;
   logic [N_CH-1:0] fault_clr;
   logic [N_CH-1:0] drv_fwd;
   logic [N_CH-1:0] drv_rev;
   logic [N_CH-1:0] busy;
   logic [N_CH-1:0] fault;

   modport master (
      output cmd_fwd, cmd_rev, lim_fwd, lim_rev, fault_clr,
      input  drv_fwd, drv_rev, busy, fault
   );

   modport slave (
      input  cmd_fwd, cmd_rev, lim_fwd, lim_rev, fault_clr,
      output drv_fwd, drv_rev, busy, fault
   );

endinterface

// File: rtl/motor_chan.sv
// motor_chan
//   One motor channel: Moore FSM with forced dead time after every stop and
//   a fault state entered when both end-of-travel switches read active.
//   Inputs : clk, rst_n (async, active-low), cmd_fwd, cmd_rev, lim_fwd,
//            lim_rev, fault_clr
//   Outputs: drv_fwd, drv_rev, busy, fault -- all registered, decoded from
//            the next state so each equals a pure function of the current
//            state and can never glitch.
//   Build option: MOTOR_CTRL_TIMEOUT_EN adds a run-time down-counter that
//   faults a channel left driving for TIMEOUT_CYC cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | stopped, waiting for a single unambiguous run request
//   ST_FWD   | forward drive on
//   ST_REV   | reverse drive on
//   ST_DEAD  | both drives off for exactly DEAD_CYC cycles, commands ignored
//   ST_FAULT | both drives off until fault_clr
module motor_chan
   import motor_ctrl_pkg::*;
#(
   parameter int DEAD_CYC    = DEAD_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cmd_fwd,
   input  logic cmd_rev,
   input  logic lim_fwd,
   input  logic lim_rev,
   input  logic fault_clr,
   output logic drv_fwd,
   output logic drv_rev,
   output logic busy,
   output logic fault
);

   if (DEAD_CYC < 1 || DEAD_CYC > 255) begin : g_bad_dead
      $error("motor_chan: DEAD_CYC out of range 1..255");
   end
   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("motor_chan: TIMEOUT_CYC out of range 2..65535");
   end

   localparam int DW = $clog2(DEAD_CYC + 1);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC);

   motor_state_e    state_q, state_d;
   logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
   logic            drv_fwd_q, drv_fwd_d;
   logic            drv_rev_q, drv_rev_d;
   logic            busy_q, busy_d;
   logic            fault_q, fault_d;
   logic            run_tc;
   logic            lim_both;

   assign lim_both = lim_fwd & lim_rev;

`ifdef MOTOR_CTRL_TIMEOUT_EN
   localparam int RW = $clog2(TIMEOUT_CYC);
   // Loaded with TIMEOUT_CYC-1 on the first drive cycle, so terminal count
   // is seen on the TIMEOUT_CYC-th drive cycle and FAULT follows next cycle.
   localparam logic [RW-1:0] RUN_LOAD = RW'(TIMEOUT_CYC - 1);

   logic [RW-1:0] run_cnt_q, run_cnt_d;

   assign run_tc = (run_cnt_q == '0);

   always_comb begin
      run_cnt_d = '0;
      if (state_d == ST_FWD || state_d == ST_REV) begin
         if (state_q == ST_IDLE) begin
            run_cnt_d = RUN_LOAD;
         end else if (run_cnt_q != '0) begin
            run_cnt_d = run_cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_q <= '0;
      end else begin
         run_cnt_q <= run_cnt_d;
      end
   end
`else
   assign run_tc = 1'b0;
`endif

   // State register (also holds the registered outputs)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         dead_cnt_q <= '0;
         drv_fwd_q  <= 1'b0;
         drv_rev_q  <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dead_cnt_q <= dead_cnt_d;
         drv_fwd_q  <= drv_fwd_d;
         drv_rev_q  <= drv_rev_d;
         busy_q     <= busy_d;
         fault_q    <= fault_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      if (state_q != ST_FAULT && lim_both) begin
         // Both switches active is physically impossible: wiring fault.
         state_d = ST_FAULT;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_fwd && !cmd_rev && !lim_fwd) begin
                  state_d = ST_FWD;
               end else if (cmd_rev && !cmd_fwd && !lim_rev) begin
                  state_d = ST_REV;
               end
            end
            ST_FWD: begin
               if (!cmd_fwd || cmd_rev || lim_fwd) begin
                  state_d = ST_DEAD;
               end else if (run_tc) begin
                  state_d = ST_FAULT;
               end
            end
            ST_REV: begin
               if (!cmd_rev || cmd_fwd || lim_rev) begin
                  state_d = ST_DEAD;
               end else if (run_tc) begin
                  state_d = ST_FAULT;
               end
            end
            ST_DEAD: begin
               // Down-counter loaded with DEAD_CYC on entry; leave on the
               // cycle it reads 1. The <= compare keeps it from wrapping.
               if (dead_cnt_q <= DW'(1)) begin
                  state_d    = ST_IDLE;
                  dead_cnt_d = '0;
               end else begin
                  dead_cnt_d = dead_cnt_q - 1'b1;
               end
            end
            ST_FAULT: begin
               if (fault_clr) begin
                  state_d = ST_DEAD;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      if (state_d == ST_DEAD && state_q != ST_DEAD) begin
         dead_cnt_d = DEAD_LOAD;
      end
   end

   // Output decode from next state, registered above
   always_comb begin
      drv_fwd_d = (state_d == ST_FWD);
      drv_rev_d = (state_d == ST_REV);
      busy_d    = (state_d != ST_IDLE);
      fault_d   = (state_d == ST_FAULT);
   end

   assign drv_fwd = drv_fwd_q;
   assign drv_rev = drv_rev_q;
   assign busy    = busy_q;
   assign fault   = fault_q;

endmodule

// File: rtl/motor_ctrl.sv
// motor_ctrl
//   N_CH independent reversible motor channels with dead time and fault
//   handling; one motor_chan per channel.
//   Ports : clk, rst_n (async, active-low), bus (motor_ctrl_if.slave)
//   Params: N_CH (1..8), DEAD_CYC (1..255), TIMEOUT_CYC (2..65535)
//   Build option: MOTOR_CTRL_TIMEOUT_EN enables the per-channel run timeout.
module motor_ctrl
   import motor_ctrl_pkg::*;
#(
   parameter int N_CH        = N_CH_DEF,
   parameter int DEAD_CYC    = DEAD_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   motor_ctrl_if.slave   bus
);

   if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
      $error("motor_ctrl: N_CH out of range 1..8");
   end

   logic [N_CH-1:0] drv_fwd_w;
   logic [N_CH-1:0] drv_rev_w;
   logic [N_CH-1:0] busy_w;
   logic [N_CH-1:0] fault_w;

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      motor_chan #(
         .DEAD_CYC    (DEAD_CYC),
         .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .cmd_fwd   (bus.cmd_fwd[i]),
         .cmd_rev   (bus.cmd_rev[i]),
         .lim_fwd   (bus.lim_fwd[i]),
         .lim_rev   (bus.lim_rev[i]),
         .fault_clr (bus.fault_clr[i]),
         .drv_fwd   (drv_fwd_w[i]),
         .drv_rev   (drv_rev_w[i]),
         .busy      (busy_w[i]),
         .fault     (fault_w[i])
      );
   end

   assign bus.drv_fwd = drv_fwd_w;
   assign bus.drv_rev = drv_rev_w;
   assign bus.busy    = busy_w;
   assign bus.fault   = fault_w;

endmodule

// File: tb/tb_motor_ctrl.sv
// tb_motor_ctrl
//   Scoreboard bench for motor_ctrl (N_CH=2, DEAD_CYC=4, TIMEOUT_CYC=50).
//   Inputs are driven on the falling edge; a behavioural channel model
//   predicts the outputs after the next rising edge and queues them; a
//   monitor pops and compares 1 time unit after each rising edge.
//   Build option: MOTOR_CTRL_TIMEOUT_EN (must match the RTL build).
module tb_motor_ctrl;

   localparam int N_CH        = 2;
   localparam int DEAD_CYC    = 4;
   localparam int TIMEOUT_CYC = 50;

`ifdef MOTOR_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int M_STOPPED = 0;
   localparam int M_RUN_FWD = 1;
   localparam int M_RUN_REV = 2;
   localparam int M_COOL    = 3;
   localparam int M_BROKEN  = 4;

   typedef struct packed {
      logic [N_CH-1:0] f;
      logic [N_CH-1:0] r;
      logic [N_CH-1:0] b;
      logic [N_CH-1:0] e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   motor_ctrl_if #(.N_CH(N_CH)) bus ();

   motor_ctrl #(
      .N_CH        (N_CH),
      .DEAD_CYC    (DEAD_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   int   mode[N_CH];
   int   cool_left[N_CH];
   int   run_len[N_CH];

   logic [N_CH-1:0] cf, cr, lf, lr;

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         mode[c]      = M_STOPPED;
         cool_left[c] = 0;
         run_len[c]   = 0;
      end
   endtask

   // Advance every channel by one clock edge given the sampled inputs.
   task automatic model_step(input logic [N_CH-1:0] f_in, r_in, lf_in,
                             lr_in, clr_in);
      for (int c = 0; c < N_CH; c++) begin
         if (mode[c] != M_BROKEN && lf_in[c] && lr_in[c]) begin
            mode[c] = M_BROKEN;
         end else if (mode[c] == M_STOPPED) begin
            if (f_in[c] && !r_in[c] && !lf_in[c]) begin
               mode[c] = M_RUN_FWD; run_len[c] = 1;
            end else if (r_in[c] && !f_in[c] && !lr_in[c]) begin
               mode[c] = M_RUN_REV; run_len[c] = 1;
            end
         end else if (mode[c] == M_RUN_FWD || mode[c] == M_RUN_REV) begin
            bit want, other, lim;
            want  = (mode[c] == M_RUN_FWD) ? f_in[c]  : r_in[c];
            other = (mode[c] == M_RUN_FWD) ? r_in[c]  : f_in[c];
            lim   = (mode[c] == M_RUN_FWD) ? lf_in[c] : lr_in[c];
            if (!want || other || lim) begin
               mode[c] = M_COOL; cool_left[c] = DEAD_CYC;
            end else if (TO_EN && run_len[c] >= TIMEOUT_CYC) begin
               mode[c] = M_BROKEN;
            end else begin
               run_len[c]++;
            end
         end else if (mode[c] == M_COOL) begin
            cool_left[c]--;
            if (cool_left[c] == 0) mode[c] = M_STOPPED;
         end else begin
            if (clr_in[c]) begin
               mode[c] = M_COOL; cool_left[c] = DEAD_CYC;
            end
         end
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      for (int c = 0; c < N_CH; c++) begin
         e.f[c] = (mode[c] == M_RUN_FWD);
         e.r[c] = (mode[c] == M_RUN_REV);
         e.b[c] = (mode[c] != M_STOPPED);
         e.e[c] = (mode[c] == M_BROKEN);
      end
      return e;
   endfunction

   task automatic apply(input logic [N_CH-1:0] clr);
      bus.cmd_fwd   = cf;
      bus.cmd_rev   = cr;
      bus.lim_fwd   = lf;
      bus.lim_rev   = lr;
      bus.fault_clr = clr;
      model_step(cf, cr, lf, lr, clr);
      exp_q.push_back(model_out());
   endtask

   task automatic drive_cycle(input logic [N_CH-1:0] clr);
      @(negedge clk);
      apply(clr);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) drive_cycle('0);
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (bus.drv_fwd !== '0 || bus.drv_rev !== '0 || bus.busy !== '0 ||
          bus.fault !== '0) begin
         errors++;
         $display("FAIL %s t=%0t got fwd=%b rev=%b busy=%b fault=%b want all 0",
                  name, $time, bus.drv_fwd, bus.drv_rev, bus.busy, bus.fault);
      end
   endtask

   // Asynchronous reset between edges; restart with the given commands.
   task automatic do_reset(input logic [N_CH-1:0] f_after, r_after);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      cf = '0; cr = '0; lf = '0; lr = '0;
      bus.cmd_fwd = '0; bus.cmd_rev = '0; bus.lim_fwd = '0;
      bus.lim_rev = '0; bus.fault_clr = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cf = f_after;
      cr = r_after;
      apply('0);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            check_all_zero("held_in_reset");
         end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.drv_fwd !== e.f || bus.drv_rev !== e.r ||
                bus.busy !== e.b || bus.fault !== e.e) begin
               errors++;
               $display("FAIL outputs t=%0t got fwd=%b rev=%b busy=%b fault=%b want fwd=%b rev=%b busy=%b fault=%b",
                        $time, bus.drv_fwd, bus.drv_rev, bus.busy, bus.fault,
                        e.f, e.r, e.b, e.e);
            end
         end
         checks++;
         if ((bus.drv_fwd & bus.drv_rev) !== '0) begin
            errors++;
            $display("FAIL drive_overlap t=%0t got fwd=%b rev=%b want no common bit",
                     $time, bus.drv_fwd, bus.drv_rev);
         end
      end
   end

   // Stimulus
   initial begin
      int k;
      cf = '0; cr = '0; lf = '0; lr = '0;
      bus.cmd_fwd = '0; bus.cmd_rev = '0; bus.lim_fwd = '0;
      bus.lim_rev = '0; bus.fault_clr = '0;
      model_reset();
      #2;
      check_all_zero("reset_state");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      apply('0);
      tick(8);

      // Forward start on channel 0, channel 1 left idle
      cf[0] = 1'b1;
      tick(10);
      // Forward limit reached: dead time then idle while still commanded
      lf[0] = 1'b1;
      tick(8);
      lf[0] = 1'b0;
      cf[0] = 1'b0;
      tick(2);

      // Start forward, then reverse request: dead time then reverse drive
      cf[0] = 1'b1;
      tick(5);
      cf[0] = 1'b0;
      cr[0] = 1'b1;
      tick(10);

      // Both limits while reversing: fault, clear, dead time, idle
      lf[0] = 1'b1;
      lr[0] = 1'b1;
      tick(2);
      lf[0] = 1'b0;
      lr[0] = 1'b0;
      cr[0] = 1'b0;
      tick(3);
      drive_cycle(2'b01);
      tick(6);

      // Conflicting request and request into active limit are ignored
      cf[1] = 1'b1; cr[1] = 1'b1;
      tick(3);
      cr[1] = 1'b0; lf[1] = 1'b1;
      tick(3);
      lf[1] = 1'b0;

      // fault_clr outside FAULT has no effect
      drive_cycle(2'b11);
      tick(3);

      // Long forward run on channel 1: timeout fault when enabled
      cf[1] = 1'b1;
      tick(60);
      cf[1] = 1'b0;
      tick(2);
      drive_cycle(2'b10);
      tick(6);

      // Reset mid-forward, release with reverse request held
      cf[0] = 1'b1;
      tick(4);
      do_reset(2'b00, 2'b01);
      tick(4);
      cr = '0;
      tick(6);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         logic [N_CH-1:0] clr;
         clr = '0;
         for (int c = 0; c < N_CH; c++) begin
            if ($urandom_range(0, 7) == 0) begin
               k = $urandom_range(0, 3);
               cf[c] = k[0];
               cr[c] = k[1];
            end
            lf[c]  = ($urandom_range(0, 15) == 0);
            lr[c]  = ($urandom_range(0, 15) == 0);
            clr[c] = ($urandom_range(0, 5) == 0);
         end
         if (n % 700 == 350) begin
            k = $urandom_range(0, 3);
            do_reset({1'b0, k[0]}, {k[1], 1'b0});
         end else begin
            drive_cycle(clr);
         end
      end

      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
